ifetch_ctrl: RTL and testbench



---
 rtl/ifetch_pkg.sv | 12 +
 rtl/ifetch_if.sv | 23 ++
 rtl/ifetch_fifo.sv | 53 +++++
 rtl/ifetch_ctrl.sv | 92 +++++++++
 tb/tb_ifetch_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// Shared widths, fetch step and controller state codes for the instruction fetch slice.
package ifetch_pkg;
    localparam int INST_W = 16;
    localparam int ADDR_W = 16;
    localparam logic [ADDR_W-1:0] PC_STEP  = 16'd2;
    localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
    localparam logic [1:0] ST_END   = 2'd3;
endpackage

// File: rtl/ifetch_if.sv
// Instruction memory bus plus the decode-side valid/ready handshake.
interface ifetch_if;
    import ifetch_pkg::*;

    logic [ADDR_W-1:0] imem_addr;
    logic              imem_reset;
    logic [7:0]        imem_data_h;
    logic [7:0]        imem_data_l;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        output imem_addr, imem_reset, inst_valid, inst_data, inst_pc,
        input  imem_data_h, imem_data_l, inst_ready
    );

    modport slave (
        input  imem_addr, imem_reset, inst_valid, inst_data, inst_pc,
        output imem_data_h, imem_data_l, inst_ready
    );
endinterface

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO holding {pc, inst} words; flush wins over push and pop.
module ifetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Push on a full FIFO is dropped even when a pop frees a slot that cycle.
    assign do_push = push && (count < CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch controller: walks the fetch PC, fills the prefetch FIFO, serves decode.
//   state    | meaning
//   IDLE     | one cycle after reset while memory settles
//   FETCH    | push one word per cycle and advance the PC
//   STALL    | FIFO full or halted; PC held
//   END      | PC beyond MAX_ADDR; drain only, left by redirect or reset
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter  int                FIFO_DEPTH = 4,
    parameter  logic [ADDR_W-1:0] RESET_PC   = 16'h0000,
    parameter  logic [ADDR_W-1:0] MAX_ADDR   = 16'd200,
    localparam int                CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    ifetch_if.master          bus,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [CW-1:0]     fifo_count
);

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic [ADDR_W-1:0]        fetch_pc;
    logic [ADDR_W-1:0]        pc_inc;
    logic [ADDR_W-1:0]        redirect_al;
    logic                     full;
    logic                     push;
    logic                     pop;
    logic [ADDR_W+INST_W-1:0] head;

    assign full        = (fifo_count == CW'(FIFO_DEPTH));
    assign redirect_al = {redirect_pc[ADDR_W-1:1], 1'b0};
    assign pc_inc      = fetch_pc + PC_STEP;
    assign push        = (state == ST_FETCH) && !halt && !redirect_valid && !full;

    // The head is withheld during a redirect so a wrong-path word never leaves.
    assign bus.inst_valid = (fifo_count != '0) && !redirect_valid;
    assign pop            = bus.inst_valid && bus.inst_ready;
    assign bus.imem_addr  = fetch_pc;
    assign bus.inst_data  = head[INST_W-1:0];
    assign bus.inst_pc    = head[ADDR_W+INST_W-1:INST_W];

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            if (redirect_al > MAX_ADDR) state_nxt = ST_END;
            else if (halt)              state_nxt = ST_STALL;
            else                        state_nxt = ST_FETCH;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_FETCH;
                ST_FETCH: begin
                    if (halt || full)          state_nxt = ST_STALL;
                    else if (pc_inc > MAX_ADDR) state_nxt = ST_END;
                end
                ST_STALL: if (!halt && !full) state_nxt = ST_FETCH;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect_valid) fetch_pc <= redirect_al;
            else if (push)      fetch_pc <= pc_inc;
        end
    end

    always_ff @(posedge clk) bus.imem_reset <= reset;

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + INST_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({fetch_pc, bus.imem_data_h, bus.imem_data_l}),
        .head  (head),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios plus random traffic against a queue model.
module tb_ifetch_ctrl;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_WAIT = 2;
    localparam int M_DONE = 3;
    localparam int DEPTH  = 4;
    localparam int MAXA   = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        rdy;
    logic [2:0]  fifo_count;
    logic [15:0] mem [256];

    int          n_tests = 0;
    int          n_fail  = 0;

    logic [31:0] q [$];
    logic [15:0] m_pc;
    int          m_mode;
    bit          m_irst;
    bit          m_init = 1'b0;

    always #5 clk = ~clk;

    ifetch_if bus ();

    assign bus.imem_data_h = mem[bus.imem_addr[8:1]][15:8];
    assign bus.imem_data_l = mem[bus.imem_addr[8:1]][7:0];
    assign bus.inst_ready  = rdy;

    ifetch_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (16'h0000),
        .MAX_ADDR   (16'd200)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fifo_count     (fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply inputs mid-cycle, then compare every output with the model.
    task automatic drive(input bit r, input bit h, input bit rv, input logic [15:0] rpc, input bit rd);
        bit exp_v;
        @(negedge clk);
        reset          = r;
        halt           = h;
        redirect_valid = rv;
        redirect_pc    = rpc;
        rdy            = rd;
        #1;
        if (m_init) begin
            exp_v = (q.size() != 0) && !rv;
            chk("imem_addr",  32'(bus.imem_addr),  32'(m_pc));
            chk("fifo_count", 32'(fifo_count),     32'(q.size()));
            chk("imem_reset", 32'(bus.imem_reset), 32'(m_irst));
            chk("inst_valid", 32'(bus.inst_valid), 32'(exp_v));
            if (exp_v) begin
                chk("inst_data", 32'(bus.inst_data), 32'(q[0][15:0]));
                chk("inst_pc",   32'(bus.inst_pc),   32'(q[0][31:16]));
            end
        end
    endtask

    // Advance the reference model across the clock edge.
    task automatic tick();
        int          sz;
        bit          v;
        bit          f;
        logic [15:0] w;
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_pc   = 16'h0000;
            m_mode = M_BOOT;
            m_irst = 1'b1;
            m_init = 1'b1;
        end else begin
            m_irst = 1'b0;
            sz     = q.size();
            v      = (sz != 0) && !redirect_valid;
            if (redirect_valid) begin
                q.delete();
                m_pc = {redirect_pc[15:1], 1'b0};
                if (int'(m_pc) > MAXA) m_mode = M_DONE;
                else if (halt)         m_mode = M_WAIT;
                else                   m_mode = M_RUN;
            end else begin
                f = (m_mode == M_RUN) && !halt && (sz < DEPTH);
                w = mem[m_pc[8:1]];
                if (v && rdy) void'(q.pop_front());
                if (f) begin
                    q.push_back({m_pc, w});
                    m_pc = m_pc + 16'd2;
                end
                case (m_mode)
                    M_BOOT: m_mode = M_RUN;
                    M_RUN: begin
                        if (halt || sz == DEPTH)   m_mode = M_WAIT;
                        else if (int'(m_pc) > MAXA) m_mode = M_DONE;
                    end
                    M_WAIT: if (!halt && sz < DEPTH) m_mode = M_RUN;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic cyc(input bit r, input bit h, input bit rv, input logic [15:0] rpc, input bit rd);
        drive(r, h, rv, rpc, rd);
        tick();
    endtask

    task automatic do_reset(input bit rd);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, rd);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, rd);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h170A;
        mem[1] = 16'h1DD0;
        reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0; rdy = 1'b1;

        // Reset release: first word appears two cycles later.
        do_reset(1'b1);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("rst_valid",      32'(bus.inst_valid), 32'h0);
        chk("rst_data",       32'(bus.inst_data),  32'h0);
        chk("rst_pc",         32'(bus.inst_pc),    32'h0);
        chk("rst_count",      32'(fifo_count),     32'h0);
        chk("rst_addr",       32'(bus.imem_addr),  32'h0);
        chk("rst_imem_reset", 32'(bus.imem_reset), 32'h1);
        tick();
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("first_valid", 32'(bus.inst_valid), 32'h1);
        chk("first_data",  32'(bus.inst_data),  32'h170A);
        chk("first_pc",    32'(bus.inst_pc),    32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("second_data", 32'(bus.inst_data),  32'h1DD0);
        chk("second_pc",   32'(bus.inst_pc),    32'h2);
        tick();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);

        // Back-pressure: fill to depth, then stream in order.
        do_reset(1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("full_count", 32'(fifo_count),    32'h4);
        chk("full_addr",  32'(bus.imem_addr), 32'h8);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
            chk("stream_valid", 32'(bus.inst_valid), 32'h1);
            chk("stream_pc",    32'(bus.inst_pc),    32'(i * 2));
            tick();
        end

        // Redirect with three entries queued, odd target gets aligned.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 16'h001D, 1'b1);
        chk("redir_pre_count", 32'(fifo_count),     32'h3);
        chk("redir_valid",     32'(bus.inst_valid), 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("redir_count", 32'(fifo_count),    32'h0);
        chk("redir_addr",  32'(bus.imem_addr), 32'h1C);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("redir_head_pc", 32'(bus.inst_pc), 32'h1C);
        tick();

        // Halt drains the FIFO and freezes the PC.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
        chk("halt_count", 32'(fifo_count), 32'h0);
        tick();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);

        // Run past MAX_ADDR, then restart from 0.
        cyc(1'b0, 1'b0, 1'b1, 16'h00BE, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("end_addr",  32'(bus.imem_addr),  32'd202);
        chk("end_valid", 32'(bus.inst_valid), 32'h0);
        chk("end_count", 32'(fifo_count),     32'h0);
        tick();
        cyc(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("restart_valid", 32'(bus.inst_valid), 32'h1);
        chk("restart_pc",    32'(bus.inst_pc),    32'h0);
        tick();

        // Reset with a full FIFO.
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("pre_rst_count", 32'(fifo_count), 32'h4);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("mid_rst_valid", 32'(bus.inst_valid), 32'h0);
        chk("mid_rst_count", 32'(fifo_count),     32'h0);
        chk("mid_rst_addr",  32'(bus.imem_addr),  32'h0);
        chk("mid_rst_imem",  32'(bus.imem_reset), 32'h1);
        tick();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 11) == 0),
                16'($urandom_range(0, 260)),
                ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
